// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a byte-addressed data memory: validates each
// request, strobes the memory for WAIT_CYCLES cycles and returns a registered response.
module lsu_mem_ctrl #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_func3,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic              resp_fault,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [2:0]        mem_func3,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam int unsigned       CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WAIT_CYCLES - 1);
   localparam logic              SINGLE_CYCLE = (WAIT_CYCLES == 1);

   state_t           state;
   logic [CNT_W-1:0] count;
   logic             lat_write;

   logic        legal;
   logic        misaligned;
   logic        range_fault;
   logic [2:0]  bytes;
   logic [32:0] last_byte;

   always_comb begin
      legal = 1'b0;
      if (req_write)
         legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010);
      else
         legal = (req_func3 == 3'b000) || (req_func3 == 3'b001) || (req_func3 == 3'b010) ||
                 (req_func3 == 3'b100) || (req_func3 == 3'b101);

      misaligned = ((req_func3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_func3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

      case (req_func3[1:0])
         2'b01:   bytes = 3'd2;
         2'b10:   bytes = 3'd4;
         default: bytes = 3'd1;
      endcase

      // Range is judged on the full 32-bit address, so the sum gets a carry bit.
      last_byte   = {1'b0, req_addr} + 33'(bytes) - 33'd1;
      range_fault = |last_byte[32:ADDR_W];
   end

   assign req_ready = (state == IDLE) && rst_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         count           <= '0;
         lat_write       <= 1'b0;
         resp_valid      <= 1'b0;
         resp_rdata      <= '0;
         resp_misaligned <= 1'b0;
         resp_fault      <= 1'b0;
         mem_read        <= 1'b0;
         mem_write       <= 1'b0;
         mem_addr        <= '0;
         mem_func3       <= '0;
         mem_wdata       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write  <= req_write;
                  resp_rdata <= '0;
                  if (misaligned || range_fault || !legal) begin
                     resp_misaligned <= misaligned;
                     resp_fault      <= range_fault || !legal;
                     resp_valid      <= 1'b1;
                     state           <= RESP;
                  end else begin
                     resp_misaligned <= 1'b0;
                     resp_fault      <= 1'b0;
                     mem_addr        <= req_addr[ADDR_W-1:0];
                     mem_func3       <= req_func3;
                     mem_wdata       <= req_wdata;
                     count           <= '0;
                     mem_read        <= !req_write;
                     mem_write       <= req_write && SINGLE_CYCLE;
                     state           <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (count == LAST) begin
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  if (!lat_write)
                     resp_rdata <= mem_rdata;
                  resp_valid <= 1'b1;
                  count      <= '0;
                  state      <= RESP;
               end else begin
                  count <= count + 1'b1;
                  // Write strobe rises on entry to the final cycle: one write edge only.
                  if (CNT_W'(count + 1'b1) == LAST)
                     mem_write <= lat_write;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Randomized bench for lsu_mem_ctrl: two instances (WAIT_CYCLES 1 and 3) share one
// memory model; responses are checked against a transaction-level reference.
module tb_lsu_mem_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sel = 1'b0;
   logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [2:0]  req_func3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;

   logic        ready_a, rvalid_a, mis_a, flt_a, mrd_a, mwr_a;
   logic [31:0] rdata_a, mwd_a, mrdata_a;
   logic [7:0]  maddr_a;
   logic [2:0]  mf3_a;
   logic        ready_b, rvalid_b, mis_b, flt_b, mrd_b, mwr_b;
   logic [31:0] rdata_b, mwd_b, mrdata_b;
   logic [7:0]  maddr_b;
   logic [2:0]  mf3_b;

   logic        o_ready, o_rvalid, o_mis, o_flt, o_mrd, o_mwr;
   logic [31:0] o_rdata, o_mwd;
   logic [7:0]  o_maddr;
   logic [2:0]  o_mf3;

   logic [7:0] dmem [256];
   logic [7:0] rmem [256];
   logic       mem_init = 1'b0;

   int n_cmp = 0;
   int n_mis = 0;
   int cyc = 0, rd_total = 0, wr_total = 0, last_wr_cyc = 0;

   always #5 clk = ~clk;

   lsu_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(1)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & ~sel), .req_ready(ready_a), .req_write(req_write),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rvalid_a), .resp_ready(resp_ready & ~sel), .resp_rdata(rdata_a),
      .resp_misaligned(mis_a), .resp_fault(flt_a),
      .mem_read(mrd_a), .mem_write(mwr_a), .mem_addr(maddr_a), .mem_func3(mf3_a),
      .mem_wdata(mwd_a), .mem_rdata(mrdata_a));

   lsu_mem_ctrl #(.ADDR_W(8), .WAIT_CYCLES(3)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid & sel), .req_ready(ready_b), .req_write(req_write),
      .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(rvalid_b), .resp_ready(resp_ready & sel), .resp_rdata(rdata_b),
      .resp_misaligned(mis_b), .resp_fault(flt_b),
      .mem_read(mrd_b), .mem_write(mwr_b), .mem_addr(maddr_b), .mem_func3(mf3_b),
      .mem_wdata(mwd_b), .mem_rdata(mrdata_b));

   function automatic logic [31:0] ext(input logic [2:0] f3, input logic [7:0] b0, b1, b2, b3);
      case (f3)
         3'b000:  return {{24{b0[7]}}, b0};
         3'b001:  return {{16{b1[7]}}, b1, b0};
         3'b100:  return {24'h0, b0};
         3'b101:  return {16'h0, b1, b0};
         default: return {b3, b2, b1, b0};
      endcase
   endfunction

   // Combinational data memory as seen by each instance.
   always_comb begin
      mrdata_a = ext(mf3_a, dmem[maddr_a], dmem[maddr_a + 8'd1], dmem[maddr_a + 8'd2], dmem[maddr_a + 8'd3]);
      mrdata_b = ext(mf3_b, dmem[maddr_b], dmem[maddr_b + 8'd1], dmem[maddr_b + 8'd2], dmem[maddr_b + 8'd3]);
   end

   always_comb begin
      o_ready  = sel ? ready_b  : ready_a;
      o_rvalid = sel ? rvalid_b : rvalid_a;
      o_rdata  = sel ? rdata_b  : rdata_a;
      o_mis    = sel ? mis_b    : mis_a;
      o_flt    = sel ? flt_b    : flt_a;
      o_mrd    = sel ? mrd_b    : mrd_a;
      o_mwr    = sel ? mwr_b    : mwr_a;
      o_maddr  = sel ? maddr_b  : maddr_a;
      o_mf3    = sel ? mf3_b    : mf3_a;
      o_mwd    = sel ? mwd_b    : mwd_a;
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!mem_init) begin
         for (int i = 0; i < 256; i++) dmem[i] <= rmem[i];
      end else begin
         if (o_mrd) rd_total <= rd_total + 1;
         if (o_mwr) begin
            wr_total    <= wr_total + 1;
            last_wr_cyc <= cyc + 1;
            dmem[o_maddr] <= o_mwd[7:0];
            if (o_mf3[1:0] != 2'b00) dmem[o_maddr + 8'd1] <= o_mwd[15:8];
            if (o_mf3[1:0] == 2'b10) begin
               dmem[o_maddr + 8'd2] <= o_mwd[23:16];
               dmem[o_maddr + 8'd3] <= o_mwd[31:24];
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold);
      int unsigned size;
      logic        ok, e_mis, e_flt, legal;
      logic [31:0] e_rdata, held;
      int          lat, t, rd0, wr0, e0, wait_n;
      longint      last_byte;

      wait_n = sel ? 3 : 1;
      size   = (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 1;
      legal  = w ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      e_mis  = (f3[1:0] == 2'b01 && a % 2 != 0) || (f3[1:0] == 2'b10 && a % 4 != 0);
      last_byte = longint'(a) + longint'(size) - 1;
      e_flt  = !legal || last_byte > 255;
      ok     = !e_mis && !e_flt;
      e_rdata = '0;
      if (ok && !w)
         e_rdata = ext(f3, rmem[a[7:0]], rmem[a[7:0] + 8'd1], rmem[a[7:0] + 8'd2], rmem[a[7:0] + 8'd3]);
      if (ok && w)
         for (int unsigned k = 0; k < size; k++) rmem[a[7:0] + 8'(k)] = wd[8*k +: 8];

      t = 0;
      while (!o_ready && t < 20) begin @(posedge clk); #1; t++; end
      check("ready_before_req", {31'h0, o_ready}, 32'h1);

      req_write = w; req_func3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
      rd0 = rd_total; wr0 = wr_total;
      @(posedge clk); #1;
      e0 = cyc;
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_func3 = 3'($urandom);

      lat = 0;
      while (!o_rvalid && lat < 20) begin @(posedge clk); #1; lat++; end
      check("latency", lat, ok ? wait_n : 0);
      check("rdata", o_rdata, e_rdata);
      check("flags", {30'h0, o_mis, o_flt}, {30'h0, e_mis, e_flt});
      check("ready_in_resp", {31'h0, o_ready}, 32'h0);
      if (ok) begin
         check("mem_addr", {24'h0, o_maddr}, {24'h0, a[7:0]});
         check("mem_func3", {29'h0, o_mf3}, {29'h0, f3});
         if (w) begin
            check("mem_wdata", o_mwd, wd);
            check("write_edge", last_wr_cyc - e0, wait_n);
         end
      end

      held = o_rdata;
      for (int i = 0; i < hold; i++) begin
         req_valid = 1'b1; req_write = 1'($urandom); req_func3 = 3'($urandom_range(0, 2));
         req_addr = $urandom_range(0, 252) & ~32'h3;
         @(posedge clk); #1;
         check("hold_valid", {31'h0, o_rvalid}, 32'h1);
         check("hold_rdata", o_rdata, held);
         check("hold_ready", {31'h0, o_ready}, 32'h0);
      end
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("valid_after_take", {31'h0, o_rvalid}, 32'h0);
      check("ready_after_take", {31'h0, o_ready}, 32'h1);
      check("read_cycles", rd_total - rd0, (ok && !w) ? wait_n : 0);
      check("write_edges", wr_total - wr0, (ok && w) ? 1 : 0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          wr0;

      for (int i = 0; i < 256; i++) rmem[i] = 8'($urandom);
      rmem[4] = 8'h09; rmem[5] = 8'h00; rmem[6] = 8'h00; rmem[7] = 8'h00;

      #2;
      check("rst_ready", {31'h0, ready_a}, 32'h0);
      check("rst_outputs", {30'h0, rvalid_a | mis_a | flt_a | mrd_a | mwr_a, |{rdata_a, maddr_a, mwd_a, mf3_a}}, 32'h0);
      repeat (2) @(posedge clk);
      mem_init = 1'b1;
      #3 rst_n = 1'b1;
      #1 check("ready_after_release", {31'h0, ready_a & ready_b}, 32'h1);
      @(negedge clk);

      sel = 1'b0; do_req(1'b0, 3'b010, 32'h04, 32'h0, 0);
      sel = 1'b1; do_req(1'b1, 3'b001, 32'h10, 32'hABCD_6001, 0);
      sel = 1'b0; do_req(1'b0, 3'b001, 32'h11, 32'h0, 0);
      do_req(1'b0, 3'b010, 32'hFE, 32'h0, 0);
      do_req(1'b1, 3'b100, 32'h20, 32'h1234_5678, 0);
      do_req(1'b0, 3'b000, 32'h100, 32'h0, 0);
      sel = 1'b1; do_req(1'b0, 3'b010, 32'hFC, 32'h0, 0);
      do_req(1'b0, 3'b010, 32'h08, 32'h0, 4);

      // Reset in the second access cycle of a three-cycle store.
      sel = 1'b1;
      wr0 = wr_total;
      req_write = 1'b1; req_func3 = 3'b010; req_addr = 32'h40; req_wdata = ~{rmem[67], rmem[66], rmem[65], rmem[64]};
      req_valid = 1'b1;
      @(posedge clk); #1; req_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      check("midrst_strobes", {30'h0, o_mwr, o_mrd}, 32'h0);
      check("midrst_outputs", {30'h0, o_rvalid | o_mis | o_flt | o_ready, |{o_rdata, o_maddr, o_mwd, o_mf3}}, 32'h0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      #1 check("midrst_ready", {31'h0, o_ready}, 32'h1);
      check("midrst_no_write", wr_total - wr0, 0);
      @(negedge clk);
      do_req(1'b0, 3'b010, 32'h40, 32'h0, 0);

      for (int n = 0; n < 60; n++) begin
         sel = 1'($urandom);
         f3  = 3'($urandom);
         a   = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 32'h10F);
         if ($urandom_range(0, 3) != 0) a = a & ~32'h3 | (a & {30'h0, f3[1:0] == 2'b00, 1'b0});
         do_req(1'($urandom), f3, a, $urandom, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
